// File: rtl/ara_resp_join_if.sv
// Handshake bundle between the per-cluster Ara responses, the CVA6 response
// port and the status outputs of ara_resp_join.
// slave  : the join block's view.
// master : the environment's view (clusters + CVA6 + status observer).
interface ara_resp_join_if #(
  parameter int unsigned NrClusters   = 4,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned TransIdWidth = 3,
  parameter int unsigned FifoDepth    = 2,
  parameter int unsigned CauseWidth   = 5
);
  localparam int unsigned OccWidth = $clog2(FifoDepth + 1);

  logic                                flush_i;
  logic [NrClusters-1:0]               clst_valid_i;
  logic [NrClusters-1:0]               clst_ready_o;
  logic [NrClusters*DataWidth-1:0]     clst_data_i;
  logic [NrClusters*TransIdWidth-1:0]  clst_id_i;
  logic [NrClusters-1:0]               clst_exc_i;
  logic [NrClusters*CauseWidth-1:0]    clst_cause_i;
  logic                                resp_valid_o;
  logic                                resp_ready_i;
  logic [DataWidth-1:0]                resp_data_o;
  logic [TransIdWidth-1:0]             resp_id_o;
  logic                                resp_exc_o;
  logic [CauseWidth-1:0]               resp_cause_o;
  logic                                mismatch_o;
  logic [NrClusters*OccWidth-1:0]      occupancy_o;

  modport slave (
    input  flush_i, clst_valid_i, clst_data_i, clst_id_i, clst_exc_i,
           clst_cause_i, resp_ready_i,
    output clst_ready_o, resp_valid_o, resp_data_o, resp_id_o, resp_exc_o,
           resp_cause_o, mismatch_o, occupancy_o
  );

  modport master (
    output flush_i, clst_valid_i, clst_data_i, clst_id_i, clst_exc_i,
           clst_cause_i, resp_ready_i,
    input  clst_ready_o, resp_valid_o, resp_data_o, resp_id_o, resp_exc_o,
           resp_cause_o, mismatch_o, occupancy_o
  );
endinterface

// File: rtl/ara_resp_join.sv
// ara_resp_join: joins the scalar responses of NrClusters Ara clusters into a
// single CVA6 accelerator response. Each cluster feeds its own small FIFO; once
// every FIFO holds a head entry, all heads are popped together and merged into
// a registered output. Clusters whose head ID disagrees with cluster 0 raise a
// sticky mismatch flag.
//
// Optional feature (macro ARA_RESP_JOIN_REDUCE_EN):
//   defined   -> merged data is the wrap-around sum of all head data words
//   undefined -> merged data is cluster 0's head data
module ara_resp_join #(
  parameter int unsigned NrClusters   = 4,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned TransIdWidth = 3,
  parameter int unsigned FifoDepth    = 2,
  parameter int unsigned CauseWidth   = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ara_resp_join_if.slave     bus
);

  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  typedef struct packed {
    logic [DataWidth-1:0]    data;
    logic [TransIdWidth-1:0] id;
    logic                    exc;
    logic [CauseWidth-1:0]   cause;
  } entry_t;

  // Advance a FIFO pointer, wrapping after the last slot.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FifoDepth - 1)) return '0;
    else                            return p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cluster FIFO state
  // ---------------------------------------------------------------------------
  entry_t mem_q   [NrClusters][FifoDepth];
  ptr_t   wr_ptr_q [NrClusters];
  ptr_t   wr_ptr_d [NrClusters];
  ptr_t   rd_ptr_q [NrClusters];
  ptr_t   rd_ptr_d [NrClusters];
  cnt_t   cnt_q    [NrClusters];
  cnt_t   cnt_d    [NrClusters];

  entry_t                entry_in [NrClusters];
  entry_t                head     [NrClusters];
  logic [NrClusters-1:0] full;
  logic [NrClusters-1:0] empty;
  logic [NrClusters-1:0] push;

  // ---------------------------------------------------------------------------
  // Output register state
  // ---------------------------------------------------------------------------
  logic   resp_valid_q, resp_valid_d;
  entry_t resp_q, resp_d;
  logic   mismatch_q, mismatch_d;

  entry_t merged;
  logic   id_mismatch;
  logic   all_head;
  logic   load;

  // Unpack the flat cluster buses and expose FIFO status per cluster.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    full  = '0;
    empty = '0;
    for (int c = 0; c < NrClusters; c++) begin
      entry_in[c].data  = bus.clst_data_i[c*DataWidth +: DataWidth];
      entry_in[c].id    = bus.clst_id_i[c*TransIdWidth +: TransIdWidth];
      entry_in[c].exc   = bus.clst_exc_i[c];
      entry_in[c].cause = bus.clst_cause_i[c*CauseWidth +: CauseWidth];
      head[c]           = mem_q[c][rd_ptr_q[c]];
      full[c]           = (cnt_q[c] == cnt_t'(FifoDepth));
      empty[c]          = (cnt_q[c] == '0);
    end
  end

  // Join condition: every cluster has a head and the output slot is free or
  // draining this cycle. A flush suppresses the join entirely.
  always_comb begin
    all_head = &(~empty);
    load     = all_head && (!resp_valid_q || bus.resp_ready_i) && !bus.flush_i;
  end

  // Merge the FIFO heads into one response and detect ID disagreement.
  always_comb begin
    merged      = '0;
    id_mismatch = 1'b0;
    merged.id   = head[0].id;
`ifdef ARA_RESP_JOIN_REDUCE_EN
    for (int c = 0; c < NrClusters; c++) begin
      merged.data = merged.data + head[c].data;
    end
`else
    merged.data = head[0].data;
`endif
    // Walk from the highest index down so the lowest excepting cluster wins.
    for (int c = NrClusters - 1; c >= 0; c--) begin
      if (head[c].exc) begin
        merged.exc   = 1'b1;
        merged.cause = head[c].cause;
      end
    end
    for (int c = 1; c < NrClusters; c++) begin
      if (head[c].id != head[0].id) id_mismatch = 1'b1;
    end
  end

  // Next-state of every FIFO's pointers and fill count.
  always_comb begin
    push = '0;
    for (int c = 0; c < NrClusters; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      push[c]     = bus.clst_valid_i[c] && !full[c] && !bus.flush_i;
      if (bus.flush_i) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        if (push[c]) wr_ptr_d[c] = ptr_inc(wr_ptr_q[c]);
        if (load)    rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
        unique case ({push[c], load})
          2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
          2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
          default: cnt_d[c] = cnt_q[c];
        endcase
      end
    end
  end

  // Next-state of the merged-response register and the sticky mismatch flag.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    mismatch_d   = mismatch_q;
    if (bus.flush_i) begin
      resp_valid_d = 1'b0;
    end else if (load) begin
      resp_valid_d = 1'b1;
      resp_d       = merged;
      if (id_mismatch) mismatch_d = 1'b1;
    end else if (resp_valid_q && bus.resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      for (int c = 0; c < NrClusters; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NrClusters; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; an entry is only ever read after a
    // push has written it, and the counters (which are reset) gate that.
    for (int c = 0; c < NrClusters; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= entry_in[c];
    end
  end

  // Merged-response and mismatch registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      mismatch_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      mismatch_q   <= mismatch_d;
    end
  end

  // Drive the interface outputs from registered state.
  always_comb begin
    bus.occupancy_o = '0;
    for (int c = 0; c < NrClusters; c++) begin
      bus.occupancy_o[c*CntWidth +: CntWidth] = cnt_q[c];
    end
    bus.clst_ready_o = ~full;
    bus.resp_valid_o = resp_valid_q;
    bus.resp_data_o  = resp_q.data;
    bus.resp_id_o    = resp_q.id;
    bus.resp_exc_o   = resp_q.exc;
    bus.resp_cause_o = resp_q.cause;
    bus.mismatch_o   = mismatch_q;
  end

endmodule

// File: tb/tb_ara_resp_join.sv
// Directed testbench for ara_resp_join (4 clusters, FIFO depth 2).
// Expected data values follow the build: with ARA_RESP_JOIN_REDUCE_EN the
// merged data is the sum of all cluster words, otherwise cluster 0's word.
module tb_ara_resp_join;

  localparam int unsigned NrClusters   = 4;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned TransIdWidth = 3;
  localparam int unsigned FifoDepth    = 2;
  localparam int unsigned CauseWidth   = 5;

`ifdef ARA_RESP_JOIN_REDUCE_EN
  localparam bit Reduce = 1'b1;
`else
  localparam bit Reduce = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  ara_resp_join_if #(
    .NrClusters  (NrClusters),
    .DataWidth   (DataWidth),
    .TransIdWidth(TransIdWidth),
    .FifoDepth   (FifoDepth),
    .CauseWidth  (CauseWidth)
  ) bus ();

  ara_resp_join #(
    .NrClusters  (NrClusters),
    .DataWidth   (DataWidth),
    .TransIdWidth(TransIdWidth),
    .FifoDepth   (FifoDepth),
    .CauseWidth  (CauseWidth)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_clst(input int c, input logic [63:0] d, input logic [2:0] id,
                          input logic e, input logic [4:0] cause);
    bus.clst_data_i[c*DataWidth +: DataWidth]        = d;
    bus.clst_id_i[c*TransIdWidth +: TransIdWidth]    = id;
    bus.clst_exc_i[c]                                = e;
    bus.clst_cause_i[c*CauseWidth +: CauseWidth]     = cause;
  endtask

  // All four clusters offer a response with the same ID and no exception.
  task automatic offer_all(input logic [2:0] id, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
    set_clst(0, d0, id, 1'b0, 5'd0);
    set_clst(1, d1, id, 1'b0, 5'd0);
    set_clst(2, d2, id, 1'b0, 5'd0);
    set_clst(3, d3, id, 1'b0, 5'd0);
    bus.clst_valid_i = 4'hF;
  endtask

  task automatic flush_pulse();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.flush_i      = 1'b0;
    bus.clst_valid_i = '0;
    bus.clst_data_i  = '0;
    bus.clst_id_i    = '0;
    bus.clst_exc_i   = '0;
    bus.clst_cause_i = '0;
    bus.resp_ready_i = 1'b1;
    #12;

    // Reset values.
    check("rst_valid",    64'(bus.resp_valid_o), 64'd0);
    check("rst_ready",    64'(bus.clst_ready_o), 64'hF);
    check("rst_occ",      64'(bus.occupancy_o),  64'h00);
    check("rst_mismatch", 64'(bus.mismatch_o),   64'd0);
    check("rst_data",     bus.resp_data_o,       64'd0);
    rst_n = 1'b1;
    step();

    // Simultaneous arrival: one edge to buffer, one edge to load.
    offer_all(3'd2, 64'h10, 64'h20, 64'h30, 64'h40);
    step();
    bus.clst_valid_i = '0;
    check("sim_occ_buffered", 64'(bus.occupancy_o),  64'h55);
    check("sim_valid_early",  64'(bus.resp_valid_o), 64'd0);
    step();
    check("sim_valid",    64'(bus.resp_valid_o), 64'd1);
    check("sim_id",       64'(bus.resp_id_o),    64'd2);
    check("sim_data",     bus.resp_data_o,       Reduce ? 64'hA0 : 64'h10);
    check("sim_mismatch", 64'(bus.mismatch_o),   64'd0);
    check("sim_occ_drained", 64'(bus.occupancy_o), 64'h00);
    step();
    check("sim_valid_clear", 64'(bus.resp_valid_o), 64'd0);

    // Staggered arrival: cluster 0 alone fills up and stalls.
    set_clst(0, 64'h1, 3'd0, 1'b0, 5'd0);
    bus.clst_valid_i = 4'b0001;
    step();
    check("stag_occ1",   64'(bus.occupancy_o),  64'h01);
    check("stag_ready1", 64'(bus.clst_ready_o), 64'hF);
    set_clst(0, 64'h2, 3'd0, 1'b0, 5'd0);
    step();
    check("stag_occ2",   64'(bus.occupancy_o),  64'h02);
    check("stag_ready2", 64'(bus.clst_ready_o), 64'hE);
    set_clst(0, 64'h3, 3'd0, 1'b0, 5'd0);
    step();
    check("stag_occ_full",  64'(bus.occupancy_o),  64'h02);
    check("stag_no_valid",  64'(bus.resp_valid_o), 64'd0);
    set_clst(1, 64'h100, 3'd0, 1'b0, 5'd0);
    set_clst(2, 64'h100, 3'd0, 1'b0, 5'd0);
    set_clst(3, 64'h100, 3'd0, 1'b0, 5'd0);
    bus.clst_valid_i = 4'b1110;
    step();
    bus.clst_valid_i = '0;
    check("stag_occ_all", 64'(bus.occupancy_o),  64'h56);
    check("stag_valid0",  64'(bus.resp_valid_o), 64'd0);
    step();
    check("stag_valid",     64'(bus.resp_valid_o), 64'd1);
    check("stag_data",      bus.resp_data_o,       Reduce ? 64'h301 : 64'h1);
    check("stag_occ_after", 64'(bus.occupancy_o),  64'h01);
    check("stag_ready_back", 64'(bus.clst_ready_o), 64'hF);
    flush_pulse();
    check("stag_flush_occ", 64'(bus.occupancy_o), 64'h00);

    // Exception merge: lowest-indexed excepting cluster provides the cause.
    set_clst(0, 64'h5, 3'd5, 1'b0, 5'd0);
    set_clst(1, 64'h0, 3'd5, 1'b0, 5'd0);
    set_clst(2, 64'h0, 3'd5, 1'b1, 5'd7);
    set_clst(3, 64'h0, 3'd5, 1'b1, 5'd4);
    bus.clst_valid_i = 4'hF;
    step();
    bus.clst_valid_i = '0;
    step();
    check("exc_valid", 64'(bus.resp_valid_o), 64'd1);
    check("exc_flag",  64'(bus.resp_exc_o),   64'd1);
    check("exc_cause", 64'(bus.resp_cause_o), 64'd7);
    check("exc_id",    64'(bus.resp_id_o),    64'd5);
    check("exc_data",  bus.resp_data_o,       64'h5);
    step();

    // Output stall: response A held while set B waits in the FIFOs.
    bus.resp_ready_i = 1'b0;
    offer_all(3'd1, 64'h11, 64'h1, 64'h1, 64'h1);
    step();
    offer_all(3'd2, 64'h22, 64'h2, 64'h2, 64'h2);
    step();
    bus.clst_valid_i = '0;
    check("stall_noexc", 64'(bus.resp_exc_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_valid_%0d", i), 64'(bus.resp_valid_o), 64'd1);
      check($sformatf("stall_id_%0d", i),    64'(bus.resp_id_o),    64'd1);
      check($sformatf("stall_data_%0d", i),  bus.resp_data_o,       Reduce ? 64'h14 : 64'h11);
      check($sformatf("stall_occ_%0d", i),   64'(bus.occupancy_o),  64'h55);
      step();
    end
    bus.resp_ready_i = 1'b1;
    step();
    check("stall_next_valid", 64'(bus.resp_valid_o), 64'd1);
    check("stall_next_id",    64'(bus.resp_id_o),    64'd2);
    check("stall_next_data",  bus.resp_data_o,       Reduce ? 64'h28 : 64'h22);
    check("stall_next_occ",   64'(bus.occupancy_o),  64'h00);
    step();
    check("stall_drained", 64'(bus.resp_valid_o), 64'd0);

    // ID mismatch: cluster 1 disagrees; flag is sticky across flush.
    set_clst(0, 64'h7, 3'd1, 1'b0, 5'd0);
    set_clst(1, 64'h0, 3'd3, 1'b0, 5'd0);
    set_clst(2, 64'h0, 3'd1, 1'b0, 5'd0);
    set_clst(3, 64'h0, 3'd1, 1'b0, 5'd0);
    bus.clst_valid_i = 4'hF;
    step();
    bus.clst_valid_i = '0;
    check("mm_before_load", 64'(bus.mismatch_o), 64'd0);
    step();
    check("mm_valid", 64'(bus.resp_valid_o), 64'd1);
    check("mm_id",    64'(bus.resp_id_o),    64'd1);
    check("mm_set",   64'(bus.mismatch_o),   64'd1);
    step();
    flush_pulse();
    check("mm_after_flush", 64'(bus.mismatch_o), 64'd1);

    // Flush with two entries buffered and a pending response; pushes offered
    // in the flush cycle are dropped.
    bus.resp_ready_i = 1'b0;
    offer_all(3'd4, 64'h40, 64'h0, 64'h0, 64'h0);
    step();
    offer_all(3'd4, 64'h41, 64'h0, 64'h0, 64'h0);
    step();
    offer_all(3'd4, 64'h42, 64'h0, 64'h0, 64'h0);
    step();
    check("fl_occ_full", 64'(bus.occupancy_o),  64'hAA);
    check("fl_ready",    64'(bus.clst_ready_o), 64'h0);
    check("fl_valid",    64'(bus.resp_valid_o), 64'd1);
    check("fl_data",     bus.resp_data_o,       64'h40);
    offer_all(3'd4, 64'h43, 64'h0, 64'h0, 64'h0);
    flush_pulse();
    bus.clst_valid_i = '0;
    check("fl_occ",       64'(bus.occupancy_o),  64'h00);
    check("fl_valid_clr", 64'(bus.resp_valid_o), 64'd0);
    check("fl_ready_all", 64'(bus.clst_ready_o), 64'hF);

    // Asynchronous reset mid-stream, observed between clock edges.
    offer_all(3'd6, 64'h60, 64'h0, 64'h0, 64'h0);
    step();
    offer_all(3'd6, 64'h61, 64'h0, 64'h0, 64'h0);
    step();
    bus.clst_valid_i = '0;
    check("ar_pre_valid", 64'(bus.resp_valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",    64'(bus.resp_valid_o), 64'd0);
    check("ar_occ",      64'(bus.occupancy_o),  64'h00);
    check("ar_ready",    64'(bus.clst_ready_o), 64'hF);
    check("ar_mismatch", 64'(bus.mismatch_o),   64'd0);
    check("ar_data",     bus.resp_data_o,       64'd0);
    check("ar_id",       64'(bus.resp_id_o),    64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ara_resp_join.md
Name: ara_resp_join

Overview:
Response-join stage sitting directly downstream of the per-cluster Ara macros and upstream of the CVA6 accelerator response port. It is the return-path counterpart of the request fork. Each cluster's scalar response (result, transaction ID, exception) is buffered per cluster. The block issues exactly one merged response to CVA6 once every cluster has answered, and flags clusters that answer out of step.

Parameters:
NrClusters, 4, number of Ara clusters joined (>=1)
DataWidth, 64, scalar result width (ELEN)
TransIdWidth, 3, accelerator transaction ID width
FifoDepth, 2, per-cluster response buffer depth (>=1)
CauseWidth, 5, exception cause width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush of all buffered state
clst_valid_i  in  NrClusters  per-cluster response valid
clst_ready_o  out  NrClusters  per-cluster response ready
clst_data_i  in  NrClusters*DataWidth  per-cluster result; cluster c occupies bits [c*DataWidth +: DataWidth]
clst_id_i  in  NrClusters*TransIdWidth  per-cluster transaction ID, same packing
clst_exc_i  in  NrClusters  per-cluster exception flag
clst_cause_i  in  NrClusters*CauseWidth  per-cluster exception cause, same packing
resp_valid_o  out  1  merged response valid
resp_ready_i  in  1  CVA6 accepts merged response
resp_data_o  out  DataWidth  merged result
resp_id_o  out  TransIdWidth  merged transaction ID
resp_exc_o  out  1  merged exception flag
resp_cause_o  out  CauseWidth  merged exception cause
mismatch_o  out  1  sticky ID-mismatch error flag
occupancy_o  out  NrClusters*$clog2(FifoDepth+1)  per-cluster FIFO fill level, same packing

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is asynchronous, active-low. On reset, all FIFOs are empty, the output register is empty, and mismatch_o=0. Reset values: resp_valid_o=0, resp_data_o/id/exc/cause=0, clst_ready_o=all 1, occupancy_o=0.
- Per-cluster FIFO c:
  - clst_ready_o[c] = !full[c]; the ready signal does not depend on clst_valid_i.
  - A push occurs on valid&&ready.
  - Pointers wrap modulo FifoDepth.
  - Push and pop in the same cycle when full is not allowed (ready is already low). Push and pop in the same cycle when partially filled keep occupancy unchanged.
- Join condition: all_head = AND over c of !empty[c]. load = all_head && (!resp_valid_o || resp_ready_i).
- On load:
  - Pop the head of every FIFO in the same edge.
  - Register the merged response; resp_valid_o=1 in the next cycle.
- Otherwise:
  - If resp_valid_o && resp_ready_i, clear resp_valid_o.
  - Output fields are held stable while resp_valid_o && !resp_ready_i.
- Latency: with empty FIFOs and all clusters pushing at cycle N, the FIFOs become non-empty at N+1, load occurs at the end of N+1, and resp_valid_o=1 at N+2. Sustained throughput is one merged response per cycle with resp_ready_i=1.
- Staggered arrival: no pop occurs until the slowest cluster has pushed. Faster clusters stall via ready once FifoDepth responses are buffered.
- Merge rules, evaluated on the FIFO heads:
  - resp_id_o = head ID of cluster 0.
  - resp_exc_o = OR of head exception flags.
  - resp_cause_o = cause of the lowest-indexed cluster with exc=1, or 0 if none.
  - resp_data_o: see Optional Feature.
- Mismatch: if on load any head ID differs from cluster 0's head ID, mismatch_o is set the next cycle and stays set until reset. The pop and the merged output proceed unchanged.
- Flush:
  - flush_i=1 empties all FIFOs and clears resp_valid_o on the next edge.
  - Flush takes priority over simultaneous push, pop and load; pushes offered in a flush cycle are discarded.
  - mismatch_o is not cleared by flush.
- NrClusters=1: the block degenerates to a FIFO plus output register with identical latency; mismatch_o stays 0.

Optional Feature:
Macro ARA_RESP_JOIN_REDUCE_EN.
- Defined: resp_data_o = sum of all head data words modulo 2^DataWidth (unsigned wrap-around), computed in the load cycle. This supports distributed scalar reductions where each cluster returns a partial sum.
- Undefined: resp_data_o = head data of cluster 0, and the other clusters' data is discarded.
- Latency, handshakes and the other fields are identical in both builds.

Test Plan:
- Simultaneous arrival: NrClusters=4; all clusters push ID=2 with data 0x10,0x20,0x30,0x40 at cycle 5, resp_ready_i=1 -> resp_valid_o=1 at cycle 7 with ID=2 and mismatch_o=0. Data is 0x10 without the macro and 0xA0 with it.
- Staggered arrival and backpressure: FifoDepth=2; cluster 0 pushes 3 responses, clusters 1-3 push nothing -> clst_ready_o[0]=0 after 2 pushes, occupancy of cluster 0 = 2, resp_valid_o stays 0. Clusters 1-3 then push once each -> one merged response appears and clst_ready_o[0] returns to 1.
- Exception merge: cluster 2 has exc=1 cause=7 and cluster 3 has exc=1 cause=4 -> resp_exc_o=1, resp_cause_o=7.
- Output stall: resp_ready_i=0 for 4 cycles with the response pending -> outputs held stable and no further pops; next pending set is loaded on the edge where resp_ready_i=1.
- ID mismatch: cluster 1 pushes ID=3 while the others push ID=1 -> resp_id_o=1, mismatch_o=1 from the cycle after load, still 1 after flush_i pulse, cleared only by rst_ni.
- Flush and reset: flush_i=1 with 2 entries buffered and resp_valid_o=1 -> next cycle occupancy all 0 and resp_valid_o=0. Asserting rst_ni=0 mid-stream gives all outputs at their reset values immediately, without waiting for a clock edge.
